// File: rtl/word_gather.sv
// Gathers M words of N bits from a valid/ready stream into ping-pong frame banks; optional flush via WORD_GATHER_FLUSH_EN.
// Latency: a frame is presented (out_valid) from the edge that accepts its last word; one frame per M cycles sustained.
// Backpressure: in_ready drops when both banks are full and returns the cycle after a frame is consumed.
module word_gather #(
    parameter int N = 2,
    parameter int M = 2
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [N-1:0]             in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [N-1:0]             out_data [M],
    output logic                     out_valid,
    input  logic                     out_ready
`ifdef WORD_GATHER_FLUSH_EN
    ,
    input  logic                     flush,
    output logic [$clog2(M+1)-1:0]   out_fill
`endif
);

    localparam int IW = (M > 1) ? $clog2(M) : 1;
    localparam int FW = $clog2(M + 1);

    typedef enum logic {
        FILLING = 1'b0,
        FULL    = 1'b1
    } bank_state_t;

    bank_state_t   state_q [2];
    bank_state_t   state_d [2];
    logic          wb_q;
    logic          rb_q;
    logic [IW-1:0] wr_idx_q;
    logic [N-1:0]  bank_q [2][M];

    logic accept;
    logic last_slot;
    logic close;
    logic consume;

    assign in_ready  = (state_q[wb_q] == FILLING) && !reset;
    assign accept    = in_valid && in_ready;
    assign last_slot = (wr_idx_q == IW'(M - 1));
    assign out_valid = (state_q[rb_q] == FULL);
    assign consume   = out_valid && out_ready;

`ifdef WORD_GATHER_FLUSH_EN
    logic          flush_idle;
    logic [FW-1:0] fill_q [2];

    // A flush with no word this cycle only closes a bank that already holds data.
    assign flush_idle = flush && !in_valid && in_ready && (wr_idx_q != '0);
    assign close      = (accept && (last_slot || flush)) || flush_idle;
`else
    assign close      = accept && last_slot;
`endif

    // Filling and draining always target different banks, so both updates can apply together.
    always_comb begin
        state_d[0] = state_q[0];
        state_d[1] = state_q[1];
        if (close) begin
            state_d[wb_q] = FULL;
        end
        if (consume) begin
            state_d[rb_q] = FILLING;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q[0] <= FILLING;
            state_q[1] <= FILLING;
            wb_q       <= 1'b0;
            rb_q       <= 1'b0;
            wr_idx_q   <= '0;
            for (int b = 0; b < 2; b++) begin
                for (int k = 0; k < M; k++) begin
                    bank_q[b][k] <= '0;
                end
            end
        end else begin
            state_q[0] <= state_d[0];
            state_q[1] <= state_d[1];
            if (close) begin
                wb_q     <= ~wb_q;
                wr_idx_q <= '0;
            end else if (accept) begin
                wr_idx_q <= wr_idx_q + IW'(1);
            end
            if (consume) begin
                rb_q <= ~rb_q;
            end
            if (accept) begin
                bank_q[wb_q][wr_idx_q] <= in_data;
            end
        end
    end

`ifdef WORD_GATHER_FLUSH_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            fill_q[0] <= '0;
            fill_q[1] <= '0;
        end else if (close) begin
            fill_q[wb_q] <= accept ? (FW'(wr_idx_q) + FW'(1)) : FW'(wr_idx_q);
        end
    end

    // Slots beyond the fill count hold stale data from an earlier frame; mask them.
    always_comb begin
        for (int k = 0; k < M; k++) begin
            out_data[k] = '0;
            if (k < int'(fill_q[rb_q])) begin
                out_data[k] = bank_q[rb_q][k];
            end
        end
        out_fill = out_valid ? fill_q[rb_q] : '0;
    end
`else
    always_comb begin
        for (int k = 0; k < M; k++) begin
            out_data[k] = bank_q[rb_q][k];
        end
    end
`endif

endmodule

// File: tb/tb_word_gather.sv
// Randomized scoreboard bench for word_gather (N=8,M=4 main instance, N=2,M=1 side instance).
module tb_word_gather;

    localparam int N = 8;
    localparam int M = 4;
`ifdef WORD_GATHER_FLUSH_EN
    localparam bit FLUSH_ON = 1'b1;
`else
    localparam bit FLUSH_ON = 1'b0;
`endif

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic         reset = 1'b1;
    logic [N-1:0] in_data = '0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [N-1:0] out_data [M];
    logic         out_valid;
    logic         out_ready = 1'b0;

    logic [1:0]   in_data1 = '0;
    logic         in_valid1 = 1'b0;
    logic         in_ready1;
    logic [1:0]   out_data1 [1];
    logic         out_valid1;
    logic         out_ready1 = 1'b0;

`ifdef WORD_GATHER_FLUSH_EN
    logic         flush = 1'b0;
    logic [2:0]   out_fill;
    logic         flush1 = 1'b0;
    logic         out_fill1;
`endif

    word_gather #(.N(N), .M(M)) u_dut (
        .clock(clock), .reset(reset),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
`ifdef WORD_GATHER_FLUSH_EN
        , .flush(flush), .out_fill(out_fill)
`endif
    );

    word_gather #(.N(2), .M(1)) u_dut1 (
        .clock(clock), .reset(reset),
        .in_data(in_data1), .in_valid(in_valid1), .in_ready(in_ready1),
        .out_data(out_data1), .out_valid(out_valid1), .out_ready(out_ready1)
`ifdef WORD_GATHER_FLUSH_EN
        , .flush(flush1), .out_fill(out_fill1)
`endif
    );

    typedef struct {
        logic [N*M-1:0] dat;
        int             fill;
    } frame_t;

    frame_t       exp_q [$];
    logic [N-1:0] partial [$];
    int           pending = 0;
    logic [1:0]   q1 [$];
    int           pending1 = 0;
    int           checks = 0;
    int           errors = 0;
    logic         after_rst = 1'b0;
    logic         a;
    logic [7:0]   nxt;
    logic [1:0]   n1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [N*M-1:0] pack_out();
        logic [N*M-1:0] r;
        r = '0;
        for (int k = 0; k < M; k++) r[k*N +: N] = out_data[k];
        return r;
    endfunction

    task automatic close_frame();
        frame_t f;
        f.dat  = '0;
        f.fill = partial.size();
        for (int i = 0; i < partial.size(); i++) f.dat[i*N +: N] = partial[i];
        exp_q.push_back(f);
        partial.delete();
        pending++;
    endtask

    // Reference model: two frame slots; ready whenever fewer than two frames are pending.
    task automatic step(input logic v, input logic [N-1:0] d, input logic ordy,
                        input logic rst, input logic fl, output logic acc);
        logic exp_rdy;
        logic cons;
        logic fl_eff;
        @(negedge clock);
        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
        reset     = rst;
`ifdef WORD_GATHER_FLUSH_EN
        flush     = fl;
`endif
        #1;
        fl_eff  = fl && FLUSH_ON;
        exp_rdy = (pending < 2) && !rst;
        chk("in_ready", {63'd0, in_ready}, {63'd0, exp_rdy});
        chk("out_valid", {63'd0, out_valid}, {63'd0, pending > 0});
        if (after_rst) chk("out_data_after_reset", {32'd0, pack_out()}, 64'd0);
        acc  = v && exp_rdy;
        cons = (pending > 0) && ordy && !rst;
        if (rst) begin
            partial.delete();
            exp_q.delete();
            pending = 0;
        end else begin
            if (cons) pending--;
            if (acc) partial.push_back(d);
            if (acc && (partial.size() == M || fl_eff)) close_frame();
            else if (!v && fl_eff && exp_rdy && partial.size() > 0) close_frame();
        end
        after_rst = rst;
    endtask

    task automatic step1(input logic v, input logic [1:0] d, input logic ordy, output logic acc);
        logic exp_rdy;
        @(negedge clock);
        in_valid1  = v;
        in_data1   = d;
        out_ready1 = ordy;
        #1;
        exp_rdy = (pending1 < 2) && !reset;
        chk("m1_in_ready", {63'd0, in_ready1}, {63'd0, exp_rdy});
        chk("m1_out_valid", {63'd0, out_valid1}, {63'd0, pending1 > 0});
        acc = v && exp_rdy;
        if ((pending1 > 0) && ordy) pending1--;
        if (acc) begin
            q1.push_back(d);
            pending1++;
        end
    endtask

    // Output monitor for the main instance: every presented frame must match the oldest expected one.
    initial begin
        forever begin
            @(negedge clock);
            #2;
            if (!reset && out_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL frame_unexpected: got out_valid=1, expected no pending frame at %0t", $time);
                end else begin
                    chk("frame_data", {32'd0, pack_out()}, {32'd0, exp_q[0].dat});
`ifdef WORD_GATHER_FLUSH_EN
                    chk("out_fill", {61'd0, out_fill}, 64'(exp_q[0].fill));
`endif
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
`ifdef WORD_GATHER_FLUSH_EN
            if (!reset && !out_valid) chk("out_fill_idle", {61'd0, out_fill}, 64'd0);
`endif
        end
    end

    initial begin
        forever begin
            @(negedge clock);
            #2;
            if (!reset && out_valid1) begin
                if (q1.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL m1_frame_unexpected: got out_valid=1, expected none at %0t", $time);
                end else begin
                    chk("m1_frame_data", {62'd0, out_data1[0]}, {62'd0, q1[0]});
                    if (out_ready1) void'(q1.pop_front());
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        @(posedge clock);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, a);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, a);

        // Back-to-back stream with the consumer always ready.
        nxt = 8'h01;
        for (int i = 0; i < 8; i++) begin
            step(1'b1, nxt, 1'b1, 1'b0, 1'b0, a);
            if (a) nxt++;
        end
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, a);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, a);

        // Backpressure: twelve offered, eight fit, then release.
        for (int i = 0; i < 12; i++) begin
            step(1'b1, nxt, 1'b0, 1'b0, 1'b0, a);
            if (a) nxt++;
        end
        for (int i = 0; i < 12; i++) begin
            step(1'b1, nxt, 1'b1, 1'b0, 1'b0, a);
            if (a) nxt++;
        end
        for (int i = 0; i < 6 && pending > 0; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, a);

        // Completing one bank in the same cycle the other is consumed.
        for (int i = 0; i < 7; i++) begin
            step(1'b1, nxt, 1'b0, 1'b0, 1'b0, a);
            if (a) nxt++;
        end
        step(1'b1, nxt, 1'b1, 1'b0, 1'b0, a);
        if (a) nxt++;
        for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, a);

        // Mid-frame reset discards the partial frame.
        step(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0, a);
        step(1'b1, 8'hBB, 1'b0, 1'b0, 1'b0, a);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, a);
        for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h11 + i), 1'b1, 1'b0, 1'b0, a);
        for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, a);

        // Partial-frame flush, then a flush with nothing gathered.
        step(1'b1, 8'h5A, 1'b0, 1'b0, 1'b0, a);
        step(1'b1, 8'h5B, 1'b0, 1'b0, 1'b0, a);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, a);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, a);
        for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, a);

        for (int i = 0; i < 2000; i++) begin
            logic v, o, r, f;
            v = ($urandom_range(0, 3) != 0);
            o = ($urandom_range(0, 2) != 0);
            r = ($urandom_range(0, 99) == 0);
            f = FLUSH_ON && ($urandom_range(0, 9) == 0);
            if (r) o = 1'b0;
            step(v, 8'($urandom), o, r, f, a);
        end
        for (int i = 0; i < 6 && (pending > 0 || partial.size() > 0); i++) begin
            step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, a);
        end
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, a);
        #5;
        chk("frames_left", 64'(exp_q.size()), 64'd0);
        out_ready = 1'b0;

        // Single-word frames: two fit, the third stalls until a frame is consumed.
        n1 = 2'd1;
        for (int i = 0; i < 3; i++) begin
            step1(1'b1, n1, 1'b0, a);
            if (a) n1++;
        end
        for (int i = 0; i < 4; i++) begin
            step1(1'b1, n1, 1'b1, a);
            if (a) n1++;
        end
        for (int i = 0; i < 300; i++) begin
            step1(($urandom_range(0, 2) != 0), 2'($urandom), ($urandom_range(0, 2) != 0), a);
        end
        for (int i = 0; i < 4; i++) step1(1'b0, 2'd0, 1'b1, a);
        #5;
        chk("m1_frames_left", 64'(q1.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/word_gather.md
# word_gather

Upstream framing stage for the per-lane register array. It accepts a stream of N-bit words on a valid/ready handshake and gathers M consecutive words into a complete frame. It then presents each frame as an unpacked array of packed words, `[N-1:0] out_data [M]`, for the downstream register stage. Two frame banks are used (ping-pong), so input can stream at one word per cycle while the previous frame waits for consumption.

## Interface
Parameters:
- `N`, default 2: word width in bits, must be ≥1.
- `M`, default 2: words per frame (unpacked array size), must be ≥1.

Ports:
- `clock`  in  1  rising-edge clock.
- `reset`  in  1  synchronous reset, active-high. One clock domain, no asynchronous reset.
- `in_data`  in  N  input word.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  block can accept a word this cycle.
- `out_data`  out  `[N-1:0] x [M]`  unpacked array, declared with size form `[M]`. Slot k holds the k-th accepted word of the frame.
- `out_valid`  out  1  `out_data` holds a complete frame.
- `out_ready`  in  1  downstream consumes the frame this cycle.
- `flush`  in  1  close a partial frame. Present only with `WORD_GATHER_FLUSH_EN`.
- `out_fill`  out  `$clog2(M+1)`  number of valid slots in the frame. Present only with `WORD_GATHER_FLUSH_EN`.

## Operation
- **State:**
  - two banks of M×N bits;
  - `full[1:0]` flags;
  - write-bank pointer `wb` and read-bank pointer `rb`, 1 bit each;
  - slot index `wr_idx`, width `max(1,$clog2(M))`, range 0..M-1.
- **Accept:** a word is accepted when `in_valid & in_ready`. It is written to `bank[wb][wr_idx]`.
  - If `wr_idx == M-1`: set `full[wb]`, toggle `wb`, set `wr_idx` to 0.
  - Otherwise: increment `wr_idx`.
- **Input ready:** `in_ready = !full[wb] & !reset`.
- **Output:** `out_valid = full[rb]` and `out_data = bank[rb]`.
  - On `out_valid & out_ready`: clear `full[rb]` and toggle `rb`.
  - The bank contents are not cleared on release.
- **Bank states:** each bank is either FILLING or FULL.
  - FILLING → FULL on acceptance of its last slot.
  - FULL → FILLING on consumption.
  - Both banks FULL: `in_ready` is 0 and input stalls.
- **Simultaneous events:** completing bank `wb` and consuming bank `rb` in the same cycle are independent. Both take effect, so there is no bubble.
- **Reset values** (applied on any clock edge with `reset` high, including mid-frame):
  - `full = 0`, `wb = rb = 0`, `wr_idx = 0`;
  - all bank bits = 0;
  - `out_valid = 0`, `out_data` = all zeros, `in_ready = 0` while `reset` is high.
  - A partial frame in progress is discarded.
- `out_data` is stable while `out_valid & !out_ready`.

## Timing
- **Latency:** when the last word of a frame is accepted at edge t, `out_valid` is 1 from t until the consuming edge.
- **Throughput:** with `out_ready` held at 1, the block accepts one word per cycle indefinitely and emits one frame every M cycles.
- **Fill time:** the first frame after reset needs M accepting edges.
- **Backpressure:** after one frame is pending unconsumed, a further M accepted words fill the second bank. `in_ready` then drops on the edge that completes it.
- **Combinational paths:** `in_ready` depends only on registers and `reset`. `out_valid` and `out_data` are registered, with no combinational path from `in_valid` or `out_ready`.

## Configuration
`WORD_GATHER_FLUSH_EN` adds the `flush` input and the `out_fill` output.

With `WORD_GATHER_FLUSH_EN` defined:
- `flush & in_valid & in_ready`: the word is written and the bank closes with fill `wr_idx+1`.
- `flush & !in_valid` with `wr_idx > 0` and `in_ready = 1`: the bank closes with fill `wr_idx`.
- `flush` with `wr_idx == 0` and no accepted word: ignored.
- Each bank stores its fill count. `out_fill` equals M for normal frames.
- Slots at index ≥ `out_fill` read as 0 on `out_data` (masked output).
- `out_fill` is 0 when `out_valid` is 0.

Without `WORD_GATHER_FLUSH_EN`: the ports do not exist and every frame is exactly M words.

## Test plan
All scenarios use N=8, M=4 unless stated.
- **Reset then stream:** `out_ready=1`, feed 0x01..0x08 back-to-back → frames {01,02,03,04} then {05,06,07,08}. Each frame has `out_valid` high for exactly 1 cycle, `in_ready` is never 0, and there is no bubble.
- **Backpressure:** `out_ready=0`, feed 12 words → 8 accepted and `in_ready` drops after the 8th. `out_data` holds {01,02,03,04} stable. Raise `out_ready` → frames emerge in order and accepting resumes the next cycle.
- **Simultaneous complete and consume:** bank A is FULL, the 4th word to bank B arrives in the same cycle as `out_ready=1` → A consumed, B is FULL on the next cycle, and `out_data` = B.
- **Mid-frame reset:** accept 0xAA, 0xBB, assert `reset` for 1 cycle, then feed 0x11..0x14 → first frame is {11,12,13,14}, `out_valid=0` and `in_ready=0` during reset.
- **M=1, N=2:** every accepted word immediately forms a frame. `wr_idx` stays 0 and `in_ready` drops only with both banks FULL.
- **Flush (`WORD_GATHER_FLUSH_EN`):** accept 0x5A, 0x5B, then `flush` without valid → `out_fill=2`, `out_data` = {5A,5B,00,00}. A flush with `wr_idx=0` produces no frame.
